// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Bus-master word copy engine for the data memory's single port. A Start
// request seen while idle copies WordCount consecutive 32-bit words from
// SrcAddr to DstAddr in ascending address order. Each word takes one read
// cycle followed by one write cycle. A one-cycle Done pulse follows the
// last write. The memory port mux outside this block hands the port to the
// engine whenever Busy is high.
//
// Ports:
//   Clk           clock, all state updates on the rising edge
//   Reset         synchronous, active-high reset
//   Start         transfer request, only looked at while idle
//   SrcAddr       source byte address (low two bits ignored)
//   DstAddr       destination byte address (low two bits ignored)
//   WordCount     number of words to copy, zero is legal
//   Busy          high while the engine owns the memory port
//   Done          one-cycle completion pulse
//   MemAddress    address to data memory
//   MemWriteData  write data to data memory (zero outside write cycles)
//   MemWrite      memory write strobe
//   MemRead       memory read enable
//   MemReadData   combinational read data, valid in the MemRead cycle
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [31:0]            SrcAddr,
    input  logic [31:0]            DstAddr,
    input  logic [COUNT_WIDTH-1:0] WordCount,
    output logic                   Busy,
    output logic                   Done,
    output logic [31:0]            MemAddress,
    output logic [31:0]            MemWriteData,
    output logic                   MemWrite,
    output logic                   MemRead,
    input  logic [31:0]            MemReadData
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word alignment mask applied when the addresses are latched.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_STEP  = 32'd4;

    state_t                 state_reg,     state_next;
    logic [31:0]            src_reg,       src_next;
    logic [31:0]            dst_reg,       dst_next;
    logic [COUNT_WIDTH-1:0] remaining_reg, remaining_next;
    logic [31:0]            buffer_reg,    buffer_next;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            remaining_reg <= '0;
            buffer_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            remaining_reg <= remaining_next;
            buffer_reg    <= buffer_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        remaining_next = remaining_reg;
        buffer_next    = buffer_reg;

        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    if (WordCount != '0) begin
                        src_next       = SrcAddr & ALIGN_MASK;
                        dst_next       = DstAddr & ALIGN_MASK;
                        remaining_next = WordCount;
                        state_next     = ST_READ;
                    end else begin
                        // Empty transfer: report completion without
                        // touching memory.
                        state_next = ST_DONE;
                    end
                end
            end

            ST_READ: begin
                buffer_next = MemReadData;
                state_next  = ST_WRITE;
            end

            ST_WRITE: begin
                // 32-bit adds wrap naturally past 0xFFFFFFFC.
                src_next       = src_reg + WORD_STEP;
                dst_next       = dst_reg + WORD_STEP;
                remaining_next = remaining_reg - COUNT_WIDTH'(1);
                if (remaining_reg == COUNT_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_READ;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. Only registered state feeds the outputs, so the memory
    // port never sees a combinational path from Start or the address inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;

        case (state_reg)
            ST_READ: begin
                Busy       = 1'b1;
                MemRead    = 1'b1;
                MemAddress = src_reg;
            end
            ST_WRITE: begin
                Busy         = 1'b1;
                MemWrite     = 1'b1;
                MemAddress   = dst_reg;
                MemWriteData = buffer_reg;
            end
            ST_DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Directed plus randomized bench for mem_copy_engine. A 1024-word memory
// model answers the engine's port. A reference memory is updated by a plain
// word-by-word copy loop. For every transfer the bench derives the cycle-by-
// cycle port activity from the copy rules and compares it each cycle. It
// also compares the whole memory image after each transfer.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [31:0]   SrcAddr;
    logic [31:0]   DstAddr;
    logic [CW-1:0] WordCount;
    logic          Busy;
    logic          Done;
    logic [31:0]   MemAddress;
    logic [31:0]   MemWriteData;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   MemReadData;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int checks = 0;
    int errors = 0;

    mem_copy_engine #(.COUNT_WIDTH(CW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .SrcAddr      (SrcAddr),
        .DstAddr      (DstAddr),
        .WordCount    (WordCount),
        .Busy         (Busy),
        .Done         (Done),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 Clk = ~Clk;

    // Memory model: combinational read, write on the rising edge.
    assign MemReadData = mem[MemAddress[11:2]];

    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddress[11:2]] <= MemWriteData;
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Port activity expected in a cycle: {Busy, Done, MemRead, MemWrite}.
    task automatic chk_port(input string tag, input logic [3:0] flags,
                            input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, ".flags"}, {28'd0, Busy, Done, MemRead, MemWrite}, {28'd0, flags});
        chk({tag, ".addr"},  MemAddress,   addr);
        chk({tag, ".wdata"}, MemWriteData, wdata);
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk({tag, ".mem"}, 32'(bad), 32'd0);
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        mem[i]     = v;
        ref_mem[i] = v;
    endtask

    // Runs one transfer. It is entered #1 after an edge and returns #1 after
    // the edge that opens the first idle cycle following Done.
    // keep_start leaves Start high and presents alt_src during the transfer.
    // Use already when Start and the inputs are still driven from such a call.
    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit keep_start, input bit already,
                            input logic [31:0] alt_src);
        logic [31:0] sa, da;
        logic [31:0] wd [$];
        int          i;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        // Reference: ascending word copy; overlap propagates naturally.
        for (int k = 0; k < n; k++) begin
            wd.push_back(ref_mem[widx(sa + 32'(4 * k))]);
            ref_mem[widx(da + 32'(4 * k))] = wd[k];
        end
        if (!already) begin
            SrcAddr   = s;
            DstAddr   = d;
            WordCount = CW'(n);
            Start     = 1'b1;
        end
        @(posedge Clk); #1;
        if (!keep_start) Start = 1'b0;
        else             SrcAddr = alt_src;
        for (int c = 1; c <= 2 * n + 2; c++) begin
            if (c <= 2 * n) begin
                i = (c - 1) / 2;
                if (c % 2 == 1) chk_port($sformatf("%s.rd%0d", tag, i), 4'b1010, sa + 32'(4 * i), 32'd0);
                else            chk_port($sformatf("%s.wr%0d", tag, i), 4'b1001, da + 32'(4 * i), wd[i]);
            end else if (c == 2 * n + 1) begin
                chk_port({tag, ".done"}, 4'b0100, 32'd0, 32'd0);
            end else begin
                chk_port({tag, ".idle"}, 4'b0000, 32'd0, 32'd0);
            end
            if (c < 2 * n + 2) begin
                @(posedge Clk); #1;
            end
        end
        chk_mem(tag);
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        SrcAddr   = '0;
        DstAddr   = '0;
        WordCount = '0;
        for (int i = 0; i < 1024; i++) set_word(i, $urandom);
        repeat (3) @(posedge Clk);
        #1;
        chk_port("reset", 4'b0000, 32'd0, 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk_port("post_reset", 4'b0000, 32'd0, 32'd0);

        // Four-word copy.
        set_word(0, 32'h11); set_word(1, 32'h22); set_word(2, 32'h33); set_word(3, 32'h44);
        run_copy("copy4", 32'h000, 32'h100, 4, 1'b0, 1'b0, 32'h0);
        chk("copy4.w64", mem[64], 32'h11);
        chk("copy4.w67", mem[67], 32'h44);

        // Zero count.
        run_copy("zero", 32'h040, 32'h080, 0, 1'b0, 1'b0, 32'h0);

        // Start held high through a 2-word copy, SrcAddr changed mid-copy.
        run_copy("held1", 32'h200, 32'h300, 2, 1'b1, 1'b0, 32'h280);
        run_copy("held2", 32'h280, 32'h300, 2, 1'b0, 1'b1, 32'h0);

        // Reset in the cycle after word 1's write on a 4-word copy.
        SrcAddr = 32'h010; DstAddr = 32'h180; WordCount = CW'(4); Start = 1'b1;
        ref_mem[widx(32'h180)] = ref_mem[widx(32'h010)];
        ref_mem[widx(32'h184)] = ref_mem[widx(32'h014)];
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk_port("rst_mid.rd2", 4'b1010, 32'h018, 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk_port("rst_mid.at", 4'b0000, 32'd0, 32'd0);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            chk_port($sformatf("rst_mid.after%0d", c), 4'b0000, 32'd0, 32'd0);
        end
        chk_mem("rst_mid");

        // Overlapping regions, dst = src + 4.
        set_word(0, 32'hA); set_word(1, 32'h0); set_word(2, 32'h0); set_word(3, 32'h0);
        run_copy("overlap", 32'h0, 32'h4, 3, 1'b0, 1'b0, 32'h0);
        chk("overlap.w1", mem[1], 32'hA);
        chk("overlap.w3", mem[3], 32'hA);

        // Misaligned source and destination, then address wrap.
        run_copy("align", 32'h103, 32'h242, 2, 1'b0, 1'b0, 32'h0);
        run_copy("wrap", 32'hFFFF_FFFC, 32'h300, 2, 1'b0, 1'b0, 32'h0);

        // Randomized transfers.
        for (int t = 0; t < 10; t++) begin
            run_copy($sformatf("rand%0d", t), $urandom, $urandom,
                     int'($urandom_range(0, 7)), 1'b0, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
